cpr_dist: RTL and testbench
===========================

// Module: cpr_dist
// PURPOSE
//  Return-path dispatcher for the N-ary minimum-s comparator tree; N = 2**IDX_W source lanes.
//  - Accepts winning records {wt, FDSSI, FDSTI, SSI, s} from the tree output on a valid/ready handshake.
//  - Buffers them in a DEPTH-entry FIFO.
//  - Delivers each record back to the source lane addressed by its FDSTI index.
//  - Records with wt=1 hold the dispatcher until that lane releases them.
// PARAMETERS
//  IDX_W    2   lane index width (FDSTI width); lane count N = 2**IDX_W
//  FDSSI_W  12  FDSSI field width
//  SSI_W    8   SSI field width
//  S_W      2   metric s field width
//  DEPTH    4   FIFO entries; power of 2, >= 2
//  TO_CYC   64  timeout cycles; used only when CPR_DIST_TIMEOUT_EN is defined
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           synchronous reset, active low
//  in_valid     in   1           tree output record valid
//  in_ready     out  1           FIFO can accept; = !full
//  in_wt        in   1           hold-until-release flag
//  in_FDSSI     in   FDSSI_W     record FDSSI
//  in_FDSTI     in   IDX_W       destination lane index
//  in_SSI       in   SSI_W       record SSI
//  in_s         in   S_W         record metric
//  lane_valid   out  N           one-hot; bit FDSTI of head entry set while PRESENT
//  lane_ready   in   N           per-lane accept
//  lane_rel     in   N           per-lane release for wt=1 records
//  lane_FDSSI   out  FDSSI_W     head record fields, broadcast to all lanes
//  lane_SSI     out  SSI_W       head record fields, broadcast to all lanes
//  lane_s       out  S_W         head record fields, broadcast to all lanes
//  busy         out  1           state != IDLE or FIFO not empty
//  drop_o       out  1           1-cycle pulse: entry discarded by timeout
// BEHAVIOUR
//  Reset values:
//  - state = IDLE; FIFO pointers and count = 0.
//  - lane_valid = 0, drop_o = 0, busy = 0, in_ready = 1.
//  - lane_* data outputs = 0.
//  - Reset mid-operation discards all entries, including a HOLD in progress.
//  FIFO:
//  - Push when in_valid & in_ready; pop only on a delivery event (below).
//  - Simultaneous push and pop while full: push is refused; in_ready stays registered at !full.
//  - Pointers wrap modulo DEPTH; count is IDX-independent, width clog2(DEPTH)+1.
//  - A record written into an empty FIFO appears at the head on the next cycle, so minimum in->lane latency is 1 cycle.
//  FSM:
//  - IDLE -> PRESENT when the FIFO is not empty.
//  - PRESENT: lane_valid = 1 << head.FDSTI.
//    - Delivery = lane_ready[head.FDSTI] & lane_valid; pop head.
//    - On delivery: if head.wt = 0, go to PRESENT (FIFO not empty after pop) or IDLE (FIFO empty).
//    - On delivery: if head.wt = 1, latch the lane index and go to HOLD.
//  - HOLD: lane_valid = 0. Wait for lane_rel[latched index], then go to PRESENT or IDLE as above.
//    - lane_rel on any other lane is ignored.
//    - lane_rel in any state other than HOLD is ignored.
//  - Back-to-back wt=0 deliveries sustain 1 record/cycle.
//  - lane_ready on non-addressed lanes never pops.
//  - lane_valid and data are stable until delivery; no change while PRESENT is stalled.
// CONFIGURATION
//  CPR_DIST_TIMEOUT_EN defined:
//  - A counter clears on entry to PRESENT or HOLD and increments each cycle in that state.
//  - At TO_CYC-1 with no delivery/release: in PRESENT the head is popped; in HOLD the state is exited.
//  - In both cases drop_o pulses for 1 cycle and the next state follows the IDLE/PRESENT rule.
//  - Delivery on the same cycle as expiry wins; no drop.
//  CPR_DIST_TIMEOUT_EN not defined:
//  - No counter; drop_o is tied 0.
//  - PRESENT and HOLD wait indefinitely.
// TESTING
//  T1: push {wt=0,FDSTI=2,SSI=8'h5A,s=1}, lane_ready=4'b0100
//      -> lane_valid=4'b0100 on the cycle after push; popped that cycle; back to IDLE; busy falls.
//  T2: push 5 records with lane_ready=0, DEPTH=4
//      -> in_ready=0 after 4th push; 5th held off; FIFO drains in order once lane_ready=4'hF.
//  T3: push wt=1 to lane 1, lane_ready[1]=1
//      -> HOLD; lane_rel[3] ignored; next record not presented until lane_rel[1]=1.
//  T4: head FDSTI=3, lane_ready=4'b0111 for 10 cycles
//      -> lane_valid stays 4'b1000 with stable data; no pop.
//  T5: rst_n=0 for 1 cycle while in HOLD with 3 entries queued
//      -> next cycle: IDLE, lane_valid=0, in_ready=1, busy=0.
//  T6: [TIMEOUT_EN, TO_CYC=8] head presented, no ready
//      -> drop_o pulses on the 8th PRESENT cycle; the next record is presented the following cycle.

Source files
------------

// File: rtl/cpr_dist.sv
// Return-path dispatcher: buffers comparator-tree winners and delivers each one to its FDSTI lane.
// Optional per-state timeout with drop pulse is enabled by defining CPR_DIST_TIMEOUT_EN.
module cpr_dist #(
  parameter int IDX_W   = 2,
  parameter int FDSSI_W = 12,
  parameter int SSI_W   = 8,
  parameter int S_W     = 2,
  parameter int DEPTH   = 4,
  parameter int TO_CYC  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_wt,
  input  logic [FDSSI_W-1:0]   in_FDSSI,
  input  logic [IDX_W-1:0]     in_FDSTI,
  input  logic [SSI_W-1:0]     in_SSI,
  input  logic [S_W-1:0]       in_s,
  output logic [(1<<IDX_W)-1:0] lane_valid,
  input  logic [(1<<IDX_W)-1:0] lane_ready,
  input  logic [(1<<IDX_W)-1:0] lane_rel,
  output logic [FDSSI_W-1:0]   lane_FDSSI,
  output logic [SSI_W-1:0]     lane_SSI,
  output logic [S_W-1:0]       lane_s,
  output logic                 busy,
  output logic                 drop_o
);

  localparam int N     = 1 << IDX_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TO_CYC < 2) begin : g_bad_param
    $error("cpr_dist: DEPTH must be a power of 2 >= 2 and TO_CYC >= 2");
  end

  typedef struct packed {
    logic               wt;
    logic [FDSSI_W-1:0] fdssi;
    logic [IDX_W-1:0]   fdsti;
    logic [SSI_W-1:0]   ssi;
    logic [S_W-1:0]     s;
  } rec_t;

  typedef enum logic [1:0] {IDLE, PRESENT, HOLD} state_t;

  rec_t             mem [DEPTH];
  rec_t             head;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  state_t           state_reg, state_next;
  logic [IDX_W-1:0] hold_idx_reg;
  logic             push, pop, deliver, rel_hit, expire, present;

  assign head     = mem[rd_ptr_reg];
  assign in_ready = (count_reg != CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;

  // Small FIFO kept in distributed storage so a fresh entry is visible at the head next cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= '{wt: in_wt, fdssi: in_FDSSI, fdsti: in_FDSTI, ssi: in_SSI, s: in_s};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      hold_idx_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (deliver && head.wt) hold_idx_reg <= head.fdsti;
    end
  end

`ifdef CPR_DIST_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYC);
  logic [TO_W-1:0] to_cnt_reg;

  assign expire = (state_reg != IDLE) && (to_cnt_reg == TO_W'(TO_CYC - 1)) && !deliver && !rel_hit;

  // Any event that leaves or re-enters PRESENT/HOLD restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n || state_reg == IDLE || deliver || rel_hit || expire) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; the IDLE/PRESENT choice looks at occupancy after this edge.
  always_comb begin
    deliver    = (state_reg == PRESENT) && lane_ready[head.fdsti];
    rel_hit    = (state_reg == HOLD) && lane_rel[hold_idx_reg];
    pop        = (state_reg == PRESENT) && (deliver || expire);
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_next != '0) state_next = PRESENT;
      PRESENT: begin
        if (deliver && head.wt) state_next = HOLD;
        else if (pop)           state_next = (count_next != '0) ? PRESENT : IDLE;
      end
      HOLD:    if (rel_hit || expire) state_next = (count_next != '0) ? PRESENT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    present    = (state_reg == PRESENT);
    busy       = (state_reg != IDLE) || (count_reg != '0);
    drop_o     = expire;
    lane_FDSSI = '0;
    lane_SSI   = '0;
    lane_s     = '0;
    if (count_reg != '0) begin
      lane_FDSSI = head.fdssi;
      lane_SSI   = head.ssi;
      lane_s     = head.s;
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign lane_valid[gi] = present && (head.fdsti == IDX_W'(gi));
  end

endmodule

// File: tb/tb_cpr_dist.sv
// Directed bench for cpr_dist: per-cycle vector table plus reset-in-HOLD and timeout sequences.
module tb_cpr_dist;

  localparam int IDX_W = 2;
  localparam int N     = 4;
`ifdef CPR_DIST_TIMEOUT_EN
  localparam int STALL = 6;
`else
  localparam int STALL = 10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_wt;
  logic [11:0] in_FDSSI;
  logic [1:0]  in_FDSTI;
  logic [7:0]  in_SSI;
  logic [1:0]  in_s;
  logic [N-1:0] lane_valid, lane_ready, lane_rel;
  logic [11:0] lane_FDSSI;
  logic [7:0]  lane_SSI;
  logic [1:0]  lane_s;
  logic        busy, drop_o;

  always #5 clk = ~clk;

  cpr_dist #(.IDX_W(IDX_W), .FDSSI_W(12), .SSI_W(8), .S_W(2), .DEPTH(4), .TO_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wt(in_wt),
    .in_FDSSI(in_FDSSI), .in_FDSTI(in_FDSTI), .in_SSI(in_SSI), .in_s(in_s),
    .lane_valid(lane_valid), .lane_ready(lane_ready), .lane_rel(lane_rel),
    .lane_FDSSI(lane_FDSSI), .lane_SSI(lane_SSI), .lane_s(lane_s),
    .busy(busy), .drop_o(drop_o)
  );

  typedef struct {
    logic       v;
    logic       wt;
    logic [1:0] fdsti;
    logic [7:0] ssi;
    logic [3:0] rdy;
    logic [3:0] rel;
    logic [3:0] e_lv;
    logic       e_ir;
    logic       e_busy;
    logic       e_dv;
    logic [7:0] e_ssi;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Record fields are derived from SSI so the bench can predict all broadcast data.
  function automatic logic [21:0] data_of(logic dv, logic [7:0] ssi);
    return dv ? {4'h9, ssi, ssi, ssi[7:6]} : 22'h0;
  endfunction

  function automatic void add(logic v, logic wt, logic [1:0] fdsti, logic [7:0] ssi,
                              logic [3:0] rdy, logic [3:0] rel, logic [3:0] e_lv,
                              logic e_ir, logic e_busy, logic e_dv, logic [7:0] e_ssi);
    vec_t t;
    t.v = v; t.wt = wt; t.fdsti = fdsti; t.ssi = ssi; t.rdy = rdy; t.rel = rel;
    t.e_lv = e_lv; t.e_ir = e_ir; t.e_busy = e_busy; t.e_dv = e_dv; t.e_ssi = e_ssi;
    vecs.push_back(t);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic wt, logic [1:0] fdsti, logic [7:0] ssi,
                       logic [3:0] rdy, logic [3:0] rel);
    in_valid = v; in_wt = wt; in_FDSTI = fdsti; in_SSI = ssi;
    in_FDSSI = {4'h9, ssi}; in_s = ssi[7:6];
    lane_ready = rdy; lane_rel = rel;
  endtask

  task automatic check_all(string tag, logic [3:0] lv, logic ir, logic bz, logic dv,
                           logic [7:0] ssi, logic drop);
    check({tag, ".lane_valid"}, 32'(lane_valid), 32'(lv));
    check({tag, ".in_ready"},   32'(in_ready),   32'(ir));
    check({tag, ".busy"},       32'(busy),       32'(bz));
    check({tag, ".data"},       32'({lane_FDSSI, lane_SSI, lane_s}), 32'(data_of(dv, ssi)));
    check({tag, ".drop_o"},     32'(drop_o),     32'(drop));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_all("reset", 4'h0, 1, 0, 0, 8'h0, 0);
    $display("[TB] reset state checked");
    next_cycle();

    // T1: single wt=0 record to lane 2, delivered on the cycle after push
    add(1, 0, 2, 8'h5A, 4'b0100, 0, 4'b0000, 1, 0, 0, 8'h00);
    add(0, 0, 0, 8'h00, 4'b0100, 0, 4'b0100, 1, 1, 1, 8'h5A);
    add(0, 0, 0, 8'h00, 4'b0000, 0, 4'b0000, 1, 0, 0, 8'h00);
    // T2: fill to full, fifth record held off, then in-order drain
    add(1, 0, 0, 8'h01, 4'h0, 0, 4'b0000, 1, 0, 0, 8'h00);
    add(1, 0, 1, 8'h02, 4'h0, 0, 4'b0001, 1, 1, 1, 8'h01);
    add(1, 0, 2, 8'h03, 4'h0, 0, 4'b0001, 1, 1, 1, 8'h01);
    add(1, 0, 3, 8'h04, 4'h0, 0, 4'b0001, 1, 1, 1, 8'h01);
    add(1, 0, 0, 8'h05, 4'h0, 0, 4'b0001, 0, 1, 1, 8'h01);
    add(1, 0, 0, 8'h05, 4'hF, 0, 4'b0001, 0, 1, 1, 8'h01);
    add(1, 0, 0, 8'h05, 4'hF, 0, 4'b0010, 1, 1, 1, 8'h02);
    add(0, 0, 0, 8'h00, 4'hF, 0, 4'b0100, 1, 1, 1, 8'h03);
    add(0, 0, 0, 8'h00, 4'hF, 0, 4'b1000, 1, 1, 1, 8'h04);
    add(0, 0, 0, 8'h00, 4'hF, 0, 4'b0001, 1, 1, 1, 8'h05);
    add(0, 0, 0, 8'h00, 4'h0, 0, 4'b0000, 1, 0, 0, 8'h00);
    // T3: wt=1 to lane 1 holds; foreign release ignored; release in PRESENT ignored
    add(1, 1, 1, 8'h31, 4'b0010, 4'b0000, 4'b0000, 1, 0, 0, 8'h00);
    add(1, 0, 1, 8'h32, 4'b0010, 4'b0000, 4'b0010, 1, 1, 1, 8'h31);
    add(0, 0, 0, 8'h00, 4'hF,    4'b1000, 4'b0000, 1, 1, 1, 8'h32);
    add(0, 0, 0, 8'h00, 4'hF,    4'b0000, 4'b0000, 1, 1, 1, 8'h32);
    add(0, 0, 0, 8'h00, 4'hF,    4'b0010, 4'b0000, 1, 1, 1, 8'h32);
    add(0, 0, 0, 8'h00, 4'h0,    4'b0010, 4'b0010, 1, 1, 1, 8'h32);
    add(0, 0, 0, 8'h00, 4'b0010, 4'b0000, 4'b0010, 1, 1, 1, 8'h32);
    add(0, 0, 0, 8'h00, 4'h0,    4'b0000, 4'b0000, 1, 0, 0, 8'h00);
    // T4: head to lane 3 stalled by ready on the other lanes
    add(1, 0, 3, 8'h44, 4'b0111, 0, 4'b0000, 1, 0, 0, 8'h00);
    for (int i = 0; i < STALL; i++) add(0, 0, 0, 8'h00, 4'b0111, 0, 4'b1000, 1, 1, 1, 8'h44);
    add(0, 0, 0, 8'h00, 4'b1000, 0, 4'b1000, 1, 1, 1, 8'h44);
    add(0, 0, 0, 8'h00, 4'b0000, 0, 4'b0000, 1, 0, 0, 8'h00);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].wt, vecs[i].fdsti, vecs[i].ssi, vecs[i].rdy, vecs[i].rel);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].e_lv, vecs[i].e_ir, vecs[i].e_busy,
                vecs[i].e_dv, vecs[i].e_ssi, 0);
      $display("[TB] vec%0d lane_valid=%b in_ready=%b busy=%b ssi=%h", i, lane_valid, in_ready, busy, lane_SSI);
      next_cycle();
    end

    // T5: reset while in HOLD with three entries queued
    drive(1, 1, 0, 8'h61, 4'b0001, 0); next_cycle();
    drive(1, 0, 0, 8'h62, 4'b0001, 0); next_cycle();
    drive(1, 0, 0, 8'h63, 4'b0000, 0); next_cycle();
    drive(1, 0, 0, 8'h64, 4'b0000, 0); next_cycle();
    drive(0, 0, 0, 8'h00, 4'b0000, 0);
    @(negedge clk);
    check_all("t5_hold", 4'b0000, 1, 1, 1, 8'h62, 0);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_all("t5_after_reset", 4'b0000, 1, 0, 0, 8'h00, 0);
    next_cycle();
    drive(0, 0, 0, 8'h00, 4'hF, 4'b0001);
    @(negedge clk);
    check_all("t5_rel_after_reset", 4'b0000, 1, 0, 0, 8'h00, 0);
    $display("[TB] t5 reset-in-hold sequence checked");
    next_cycle();

    // T6: head to lane 2 never accepted
    drive(1, 0, 2, 8'h71, 4'b0000, 0); next_cycle();
    drive(1, 0, 2, 8'h72, 4'b0000, 0);
`ifdef CPR_DIST_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check_all($sformatf("t6_present%0d", c), 4'b0100, 1, 1, 1, 8'h71, (c == 8));
      next_cycle();
      drive(0, 0, 0, 8'h00, 4'b0000, 0);
    end
    @(negedge clk);
    check_all("t6_next_head", 4'b0100, 1, 1, 1, 8'h72, 0);
`else
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check_all($sformatf("t6_wait%0d", c), 4'b0100, 1, 1, 1, 8'h71, 0);
      next_cycle();
      drive(0, 0, 0, 8'h00, 4'b0000, 0);
    end
`endif
    $display("[TB] t6 stalled-head sequence checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
